dp_pool_ctrl: RTL

- Sequencer for the 3x3 max-pooling datapath in the dp engine.
- Walks a programmed feature map window by window and emits element addresses to the source streamer, one window (WIN*WIN elements) at a time.
- Waits for the pooling result handshake before issuing the next window, presents the output address to the sink streamer, and reports busy/done/error to the engine register file.

---
 rtl/dp_package.sv | 24 ++
 rtl/dp_pool_addr_gen.sv | 91 +++++++++
 rtl/dp_pool_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dp_package.sv
// Shared types for the dp engine 3x3 max-pool sequencer.
// Pool window edge, controller states and the latched job configuration.
package dp_package;

    localparam int POOL_WIN    = 3;
    localparam int POOL_ADDR_W = 32;
    localparam int POOL_DIM_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RES,
        DONE
    } pool_ctrl_state_t;

    typedef struct packed {
        logic [POOL_ADDR_W-1:0] in_base;
        logic [POOL_ADDR_W-1:0] out_base;
        logic [POOL_DIM_W-1:0]  in_w;
        logic [POOL_DIM_W-1:0]  in_h;
        logic [1:0]             stride;
    } pool_cfg_t;

endpackage

// File: rtl/dp_pool_addr_gen.sv
// Window/element walker for the max-pool sequencer.
// Running sums only: stride steps use shift-add, never a multiplier.
module dp_pool_addr_gen
    import dp_package::*;
#(
    parameter int ADDR_WIDTH = POOL_ADDR_W,
    parameter int DIM_WIDTH  = POOL_DIM_W,
    parameter int WIN        = POOL_WIN
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [DIM_WIDTH-1:0]  in_w_i,
    input  logic [DIM_WIDTH-1:0]  in_h_i,
    input  logic [1:0]            stride_i,
    input  logic                  init_i,
    input  logic                  advance_elem_i,
    input  logic                  advance_win_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_elem_o,
    output logic                  last_win_o
);

    localparam int KW = $clog2(WIN);
    localparam int XW = DIM_WIDTH + 2;
    localparam logic [KW-1:0] KMAX = KW'(WIN - 1);

    logic [DIM_WIDTH-1:0]  xs_q, ys_q;
    logic [KW-1:0]         kx_q, ky_q;
    logic [ADDR_WIDTH-1:0] win_off_q, row_off_q;
    logic [ADDR_WIDTH-1:0] w_ext, row_step;
    logic [XW-1:0]         x_next, y_next;
    logic                  x_fit, y_fit;

    assign w_ext    = ADDR_WIDTH'(in_w_i);
    assign row_step = (stride_i[1] ? (w_ext << 1) : '0)
                    + (stride_i[0] ? w_ext : '0);

    assign x_next = XW'(xs_q) + XW'(stride_i) + XW'(WIN);
    assign y_next = XW'(ys_q) + XW'(stride_i) + XW'(WIN);
    assign x_fit  = x_next <= XW'(in_w_i);
    assign y_fit  = y_next <= XW'(in_h_i);

    assign last_elem_o = (kx_q == KMAX) && (ky_q == KMAX);
    assign last_win_o  = !x_fit && !y_fit;

    assign addr_o = base_i + row_off_q
                  + ADDR_WIDTH'(xs_q) + ADDR_WIDTH'(kx_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            xs_q      <= '0;
            ys_q      <= '0;
            kx_q      <= '0;
            ky_q      <= '0;
            win_off_q <= '0;
            row_off_q <= '0;
        end else if (init_i) begin
            xs_q      <= '0;
            ys_q      <= '0;
            kx_q      <= '0;
            ky_q      <= '0;
            win_off_q <= '0;
            row_off_q <= '0;
        end else if (advance_elem_i) begin
            if (kx_q == KMAX) begin
                kx_q <= '0;
                if (ky_q == KMAX) begin
                    ky_q      <= '0;
                    row_off_q <= win_off_q;
                end else begin
                    ky_q      <= ky_q + KW'(1);
                    row_off_q <= row_off_q + w_ext;
                end
            end else begin
                kx_q <= kx_q + KW'(1);
            end
        end else if (advance_win_i) begin
            // element walk already rewound row_off to the window's top row
            if (x_fit) begin
                xs_q <= xs_q + DIM_WIDTH'(stride_i);
            end else begin
                xs_q      <= '0;
                ys_q      <= ys_q + DIM_WIDTH'(stride_i);
                win_off_q <= win_off_q + row_step;
                row_off_q <= win_off_q + row_step;
            end
        end
    end

endmodule

// File: rtl/dp_pool_ctrl.sv
// Max-pool window sequencer: issues WIN*WIN element addresses per window.
// Optional DP_POOL_CTRL_PERF_EN adds busy/stall cycle counters.
module dp_pool_ctrl
    import dp_package::*;
#(
    parameter int ADDR_WIDTH = POOL_ADDR_W,
    parameter int DIM_WIDTH  = POOL_DIM_W,
    parameter int WIN        = POOL_WIN
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   clear_i,
    input  logic [ADDR_WIDTH-1:0]  in_base_i,
    input  logic [ADDR_WIDTH-1:0]  out_base_i,
    input  logic [DIM_WIDTH-1:0]   in_w_i,
    input  logic [DIM_WIDTH-1:0]   in_h_i,
    input  logic [1:0]             stride_i,
    output logic                   addr_valid_o,
    input  logic                   addr_ready_i,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    input  logic                   res_valid_i,
    input  logic                   res_ready_i,
    output logic [ADDR_WIDTH-1:0]  out_addr_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [2*DIM_WIDTH-1:0] nout_o
`ifdef DP_POOL_CTRL_PERF_EN
    ,
    output logic [31:0]            perf_cycles_o,
    output logic [31:0]            perf_stall_o
`endif
);

    pool_ctrl_state_t state_q;
    pool_cfg_t        cfg_q, cfg_d;
    logic             legal, res_hs, addr_acc, start_acc;
    logic             last_elem, last_win;

    assign cfg_d = '{in_base:  in_base_i,
                     out_base: out_base_i,
                     in_w:     in_w_i,
                     in_h:     in_h_i,
                     stride:   stride_i};

    assign legal = (in_w_i >= DIM_WIDTH'(WIN))
                && (in_h_i >= DIM_WIDTH'(WIN))
                && (stride_i != 2'd0);

    assign res_hs    = res_valid_i && res_ready_i;
    assign addr_acc  = addr_valid_o && addr_ready_i;
    assign start_acc = (state_q == IDLE) && start_i && !clear_i;

    assign out_addr_o = cfg_q.out_base + ADDR_WIDTH'(nout_o);

    dp_pool_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH),
        .WIN        (WIN)
    ) u_addr_gen (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .base_i         (cfg_q.in_base),
        .in_w_i         (cfg_q.in_w),
        .in_h_i         (cfg_q.in_h),
        .stride_i       (cfg_q.stride),
        .init_i         (start_acc && legal),
        .advance_elem_i (addr_acc && !clear_i),
        .advance_win_i  ((state_q == WAIT_RES) && res_hs && !clear_i),
        .addr_o         (addr_o),
        .last_elem_o    (last_elem),
        .last_win_o     (last_win)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cfg_q        <= '0;
            addr_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            nout_o       <= '0;
        end else begin
            done_o <= 1'b0;
            if (clear_i) begin
                state_q      <= IDLE;
                addr_valid_o <= 1'b0;
                busy_o       <= 1'b0;
            end else begin
                // a result outside the wait window is a protocol error
                if (res_hs && state_q != WAIT_RES) err_o <= 1'b1;
                unique case (state_q)
                    IDLE: if (start_i) begin
                        cfg_q  <= cfg_d;
                        nout_o <= '0;
                        err_o  <= !legal;
                        if (legal) begin
                            state_q      <= ISSUE;
                            addr_valid_o <= 1'b1;
                            busy_o       <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                        end
                    end
                    ISSUE: if (addr_acc && last_elem) begin
                        addr_valid_o <= 1'b0;
                        state_q      <= WAIT_RES;
                    end
                    WAIT_RES: if (res_hs) begin
                        nout_o <= nout_o + (2*DIM_WIDTH)'(1);
                        if (last_win) begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                            busy_o  <= 1'b0;
                        end else begin
                            state_q      <= ISSUE;
                            addr_valid_o <= 1'b1;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef DP_POOL_CTRL_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cycles_o <= '0;
            perf_stall_o  <= '0;
        end else if (start_acc) begin
            perf_cycles_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (busy_o && !(&perf_cycles_o))
                perf_cycles_o <= perf_cycles_o + 32'd1;
            if (addr_valid_o && !addr_ready_i && !(&perf_stall_o))
                perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule
